// File: rtl/alu32_issue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu32_issue_if : command, alu32 operand/result and response signals    |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
interface alu32_issue_if #(
  parameter int DW = 32,
  parameter int AW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_ldi;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_ra;
  logic [AW-1:0] cmd_rb;
  logic [DW-1:0] cmd_imm;

  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_result;
  logic          alu_c;
  logic          alu_n;
  logic          alu_z;
  logic          alu_v;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [3:0]    rsp_flags;

  modport slave (
    input  cmd_valid, cmd_ldi, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm,
    input  alu_result, alu_c, alu_n, alu_z, alu_v, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_flags
  );

  modport master (
    output cmd_valid, cmd_ldi, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm,
    output alu_result, alu_c, alu_n, alu_z, alu_v, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_flags
  );
endinterface
`default_nettype wire

// File: rtl/alu32_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu32_issue : register file + one-at-a-time command front end for alu32 |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module alu32_issue #(
  parameter int DW   = 32,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  alu32_issue_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] regs_q [NREG];
  logic [AW-1:0] rd_q;
  logic [DW-1:0] alu_a_q, alu_b_q;
  logic [2:0]    alu_op_q;
  logic [DW-1:0] rsp_data_q;
  logic [3:0]    flags_q;

  logic          w_accept;

  assign w_accept = (state_q == IDLE) && bus.cmd_valid;

  always_comb begin
    state_d       = state_q;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_d = bus.cmd_ldi ? RESP : EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_data_q <= '0;
      flags_q    <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        if (bus.cmd_ldi) begin
          regs_q[bus.cmd_rd] <= bus.cmd_imm;
          rsp_data_q         <= bus.cmd_imm;
        end else begin
          // Sources are read here, so rd aliasing ra/rb is harmless.
          alu_a_q  <= regs_q[bus.cmd_ra];
          alu_b_q  <= regs_q[bus.cmd_rb];
          alu_op_q <= bus.cmd_op;
          rd_q     <= bus.cmd_rd;
        end
      end
      if (state_q == EXEC) begin
        regs_q[rd_q] <= bus.alu_result;
        rsp_data_q   <= bus.alu_result;
        flags_q      <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
      end
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flags = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu32_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu32_issue : directed bench with a behavioural alu32 attached      |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_alu32_issue;

  logic clk = 1'b0;
  logic reset_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu32_issue_if #(.DW(32), .AW(3)) bus ();

  alu32_issue #(.DW(32), .NREG(8), .AW(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // Behavioural alu32: C is carry-out of a+b or a+~b+1 (no-borrow on SUB).
  logic [32:0] m_sum;
  logic [31:0] m_res;
  logic        m_c, m_v;
  always_comb begin
    m_sum = '0;
    m_res = '0;
    m_c   = 1'b0;
    m_v   = 1'b0;
    case (bus.alu_op)
      3'd0: m_res = ~bus.alu_a;
      3'd1: m_res = ~bus.alu_b;
      3'd2: m_res = bus.alu_a & bus.alu_b;
      3'd3: m_res = bus.alu_a | bus.alu_b;
      3'd4: m_res = bus.alu_a ^ bus.alu_b;
      3'd5: m_res = ~(bus.alu_a ^ bus.alu_b);
      3'd6: begin
        m_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        m_res = m_sum[31:0];
        m_c   = m_sum[32];
        m_v   = (bus.alu_a[31] == bus.alu_b[31]) && (m_res[31] != bus.alu_a[31]);
      end
      default: begin
        m_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
        m_res = m_sum[31:0];
        m_c   = m_sum[32];
        m_v   = (bus.alu_a[31] != bus.alu_b[31]) && (m_res[31] != bus.alu_a[31]);
      end
    endcase
  end
  assign bus.alu_result = m_res;
  assign bus.alu_n      = m_res[31];
  assign bus.alu_z      = (m_res == 32'd0);
  assign bus.alu_c      = m_c;
  assign bus.alu_v      = m_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one step after the accept edge.
  task automatic issue(input logic ldi, input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] ra, input logic [2:0] rb, input logic [31:0] imm);
    bus.cmd_valid = 1'b1;
    bus.cmd_ldi   = ldi;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_ra    = ra;
    bus.cmd_rb    = rb;
    bus.cmd_imm   = imm;
    for (int i = 0; i < 20 && bus.cmd_ready !== 1'b1; i++) step();
    check("cmd_accept", {31'd0, bus.cmd_ready}, 32'd1);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input logic [31:0] exp_data, input logic [3:0] exp_flags);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20 && bus.rsp_valid !== 1'b1; i++) step();
    check({tag, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    check({tag, "_data"}, bus.rsp_data, exp_data);
    check({tag, "_flags"}, {28'd0, bus.rsp_flags}, {28'd0, exp_flags});
    step();
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_ldi   = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_rd    = 3'd0;
    bus.cmd_ra    = 3'd0;
    bus.cmd_rb    = 3'd0;
    bus.cmd_imm   = 32'd0;
    bus.rsp_ready = 1'b1;
    step();
    step();
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_op", {29'd0, bus.alu_op}, 32'd0);
    reset_n = 1'b1;
    step();

    // 1: LDI latency T+1, ADD latency T+2
    issue(1'b1, 3'd0, 3'd1, 3'd0, 3'd0, 32'd5);
    check("ldi_lat", {31'd0, bus.rsp_valid}, 32'd1);
    wait_rsp("ldi5", 32'd5, 4'b0000);
    issue(1'b1, 3'd0, 3'd2, 3'd0, 3'd0, 32'd3);
    wait_rsp("ldi3", 32'd3, 4'b0000);
    issue(1'b0, 3'd6, 3'd3, 3'd1, 3'd2, 32'd0);
    check("add_lat_t1", {31'd0, bus.rsp_valid}, 32'd0);
    step();
    check("add_lat_t2", {31'd0, bus.rsp_valid}, 32'd1);
    wait_rsp("add8", 32'd8, 4'b0000);

    // 2: 3 - 5
    issue(1'b1, 3'd0, 3'd1, 3'd0, 3'd0, 32'd3);
    wait_rsp("ldi_a3", 32'd3, 4'b0000);
    issue(1'b1, 3'd0, 3'd2, 3'd0, 3'd0, 32'd5);
    wait_rsp("ldi_b5", 32'd5, 4'b0000);
    issue(1'b0, 3'd7, 3'd3, 3'd1, 3'd2, 32'd0);
    wait_rsp("sub", 32'hFFFF_FFFE, 4'b1000);

    // 3: signed overflow, then wrap to zero with carry
    issue(1'b1, 3'd0, 3'd1, 3'd0, 3'd0, 32'h7FFF_FFFF);
    wait_rsp("ldi_max", 32'h7FFF_FFFF, 4'b1000);
    issue(1'b1, 3'd0, 3'd2, 3'd0, 3'd0, 32'd1);
    wait_rsp("ldi_one", 32'd1, 4'b1000);
    issue(1'b0, 3'd6, 3'd3, 3'd1, 3'd2, 32'd0);
    wait_rsp("add_ovf", 32'h8000_0000, 4'b1001);
    issue(1'b1, 3'd0, 3'd1, 3'd0, 3'd0, 32'hFFFF_FFFF);
    wait_rsp("ldi_keepflags", 32'hFFFF_FFFF, 4'b1001);
    issue(1'b0, 3'd6, 3'd3, 3'd1, 3'd2, 32'd0);
    wait_rsp("add_wrap", 32'd0, 4'b0110);

    // 4: back-pressure; a stray command must be ignored
    bus.rsp_ready = 1'b0;
    issue(1'b0, 3'd2, 3'd3, 3'd1, 3'd2, 32'd0);
    step();
    bus.cmd_valid = 1'b1;
    bus.cmd_ldi   = 1'b1;
    bus.cmd_rd    = 3'd6;
    bus.cmd_imm   = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("hold_data", bus.rsp_data, 32'd1);
      check("hold_flags", {28'd0, bus.rsp_flags}, 32'b0000);
      check("hold_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      step();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    check("release_idle", {31'd0, bus.cmd_ready}, 32'd1);
    check("release_valid", {31'd0, bus.rsp_valid}, 32'd0);
    issue(1'b0, 3'd3, 3'd7, 3'd6, 3'd6, 32'd0);
    wait_rsp("r6_untouched", 32'd0, 4'b0100);

    // 5: rd == ra == rb, plus remaining logic ops
    issue(1'b1, 3'd0, 3'd4, 3'd0, 3'd0, 32'hA5A5_A5A5);
    wait_rsp("ldi_a5", 32'hA5A5_A5A5, 4'b0100);
    issue(1'b0, 3'd0, 3'd5, 3'd4, 3'd0, 32'd0);
    wait_rsp("not_a", 32'h5A5A_5A5A, 4'b0000);
    issue(1'b0, 3'd4, 3'd4, 3'd4, 3'd4, 32'd0);
    wait_rsp("xor_self", 32'd0, 4'b0100);
    issue(1'b0, 3'd3, 3'd5, 3'd4, 3'd4, 32'd0);
    wait_rsp("r4_readback", 32'd0, 4'b0100);
    issue(1'b0, 3'd5, 3'd5, 3'd2, 3'd2, 32'd0);
    wait_rsp("xnor_self", 32'hFFFF_FFFF, 4'b1000);
    issue(1'b0, 3'd1, 3'd5, 3'd0, 3'd1, 32'd0);
    wait_rsp("not_b", 32'd0, 4'b0100);

    // 6: reset while in EXEC discards the command and clears all registers
    issue(1'b0, 3'd6, 3'd3, 3'd1, 3'd2, 32'd0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("mid_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("mid_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("mid_rst_data", bus.rsp_data, 32'd0);
    check("mid_rst_flags", {28'd0, bus.rsp_flags}, 32'd0);
    for (int r = 0; r < 8; r++) begin
      issue(1'b0, 3'd3, r[2:0], r[2:0], r[2:0], 32'd0);
      wait_rsp("reg_zero", 32'd0, 4'b0100);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
